rom_load_ctrl: RTL and testbench

ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

---
 rtl/rom_load_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_rom_load_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rom_load_ctrl
// Description : Routes a byte-wide ROM download stream into up to four
//               address regions. It raises a one-hot write strobe for the
//               matching region, counts accepted bytes and flags bytes that
//               fall outside every region. The game core is held in reset
//               during the download and for a stretch afterwards.
//
// Ports       : clk_sys        - sole clock
//               reset          - synchronous, active-high reset
//               ioctl_download - high while the ROM stream is active
//               ioctl_wr       - one-cycle byte-valid strobe
//               ioctl_addr     - 25-bit byte address
//               ioctl_data     - byte value
//               rom_we         - one-hot write strobe, bit n = region n
//               rom_addr       - byte offset inside the selected region
//               rom_data       - registered byte
//               game_reset     - high while the core must stay in reset
//               load_done      - high once a load plus hold has completed
//               oob_err        - sticky, a byte hit no region
//               byte_count     - accepted bytes this load, saturating
//               checksum       - (ROM_CHECKSUM_EN only) 16-bit byte sum
//
// Options     : define ROM_CHECKSUM_EN to add the checksum output.
//
// Revision    : 1.0 - initial release
// ============================================================================
module rom_load_ctrl #(
    parameter logic [16:0] BASE0       = 17'h00000,
    parameter logic [16:0] BASE1       = 17'h04000,
    parameter logic [16:0] BASE2       = 17'h08000,
    parameter logic [16:0] BASE3       = 17'h0C000,
    parameter int          AW0         = 14,
    parameter int          AW1         = 14,
    parameter int          AW2         = 14,
    parameter int          AW3         = 14,
    parameter int          HOLD_CYCLES = 1024
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    output logic [3:0]  rom_we,
    output logic [15:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        game_reset,
    output logic        load_done,
    output logic        oob_err,
    output logic [16:0] byte_count
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    localparam logic [16:0] C_BASE [4] = '{BASE0, BASE1, BASE2, BASE3};
    localparam int          C_AW   [4] = '{AW0, AW1, AW2, AW3};

    // A zero hold length still needs one HOLD cycle to reach RUN.
    localparam int          C_HOLD_EFF  = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam logic [31:0] C_HOLD_INIT = 32'(C_HOLD_EFF - 1);

    localparam logic [16:0] C_COUNT_MAX = 17'h1FFFF;

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [31:0] r_hold_cnt;

    logic [3:0]  w_hit;
    logic [15:0] w_off [4];
    logic [3:0]  w_sel_we;
    logic [15:0] w_sel_off;
    logic        w_hit_any;
    logic        w_accept;
    logic        w_load_start;

`ifdef ROM_CHECKSUM_EN
    logic [15:0] r_checksum;
    assign checksum = r_checksum;
`endif

    // ------------------------------------------------------------------
    // Region decode. Comparisons are done one bit wider than the address
    // so a region touching the top of the 25-bit space cannot wrap.
    // ------------------------------------------------------------------
    generate
        for (genvar n = 0; n < 4; n++) begin : g_region
            logic [25:0] w_lo;
            logic [25:0] w_hi;
            assign w_lo     = {9'd0, C_BASE[n]};
            assign w_hi     = w_lo + (26'd1 << C_AW[n]);
            assign w_hit[n] = ({1'b0, ioctl_addr} >= w_lo) &&
                              ({1'b0, ioctl_addr} <  w_hi);
            // Low 16 bits of a difference depend only on the low 16 bits
            // of the operands, so the offset is computed at that width.
            assign w_off[n] = ioctl_addr[15:0] - C_BASE[n][15:0];
        end
    endgenerate

    // Lowest-index region wins: scan from the top so the last
    // assignment belongs to the smallest matching index.
    always_comb begin
        w_sel_we  = 4'd0;
        w_sel_off = 16'd0;
        w_hit_any = 1'b0;
        for (int n = 3; n >= 0; n--) begin
            if (w_hit[n]) begin
                w_sel_we  = 4'b0001 << n;
                w_sel_off = w_off[n];
                w_hit_any = 1'b1;
            end
        end
    end

    // Writes are taken only in LOAD; this includes the cycle in which
    // ioctl_download has just dropped, because the state is still LOAD.
    assign w_accept     = (r_state == S_LOAD) && ioctl_wr;

    // Outside LOAD, download high always means a new load begins.
    assign w_load_start = ioctl_download && (r_state != S_LOAD);

    assign game_reset   = (r_state != S_RUN);

    // ------------------------------------------------------------------
    // Control and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= 32'd0;
            rom_we     <= 4'd0;
            rom_addr   <= 16'd0;
            rom_data   <= 8'd0;
            load_done  <= 1'b0;
            oob_err    <= 1'b0;
            byte_count <= 17'd0;
`ifdef ROM_CHECKSUM_EN
            r_checksum <= 16'd0;
`endif
        end else begin
            rom_we <= 4'd0;

            if (w_accept) begin
                if (w_hit_any) begin
                    rom_we   <= w_sel_we;
                    rom_addr <= w_sel_off;
                    rom_data <= ioctl_data;
                    if (byte_count != C_COUNT_MAX) begin
                        byte_count <= byte_count + 17'd1;
                    end
`ifdef ROM_CHECKSUM_EN
                    r_checksum <= r_checksum + {8'd0, ioctl_data};
`endif
                end else begin
                    oob_err <= 1'b1;
                end
            end

            // A new load wipes the per-load status. It never coincides
            // with an accepted write because that needs state LOAD.
            if (w_load_start) begin
                load_done  <= 1'b0;
                oob_err    <= 1'b0;
                byte_count <= 17'd0;
`ifdef ROM_CHECKSUM_EN
                r_checksum <= 16'd0;
`endif
            end

            case (r_state)
                S_IDLE: begin
                    if (ioctl_download) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!ioctl_download) begin
                        r_state    <= S_HOLD;
                        r_hold_cnt <= C_HOLD_INIT;
                    end
                end
                S_HOLD: begin
                    if (ioctl_download) begin
                        r_state <= S_LOAD;
                    end else if (r_hold_cnt == 32'd0) begin
                        r_state   <= S_RUN;
                        load_done <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 32'd1;
                    end
                end
                S_RUN: begin
                    if (ioctl_download) begin
                        r_state <= S_LOAD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rom_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_load_ctrl
// Description : Self-checking bench for rom_load_ctrl. A behavioural model
//               follows the load rules cycle by cycle and every output is
//               compared after each clock edge; directed scenarios add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_load_ctrl;

    localparam int HOLD = 4;
    localparam int TB_BASE [4] = '{'h00000, 'h04000, 'h08000, 'h0C000};
    localparam int TB_AW   [4] = '{14, 14, 14, 14};

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_data = 8'd0;
    logic [3:0]  rom_we;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        game_reset;
    logic        load_done;
    logic        oob_err;
    logic [16:0] byte_count;
`ifdef ROM_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    rom_load_ctrl #(.HOLD_CYCLES(HOLD)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .rom_we         (rom_we),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .game_reset     (game_reset),
        .load_done      (load_done),
        .oob_err        (oob_err),
        .byte_count     (byte_count)
`ifdef ROM_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;
    int region_hits [4] = '{0, 0, 0, 0};

    // ------------------------------------------------------------------
    // Behavioural model: phase 0 idle, 1 loading, 2 holding, 3 running.
    // hold_left counts the HOLD cycles still to be spent.
    // ------------------------------------------------------------------
    int          m_phase = 0;
    int          m_hold_left = 0;
    logic [3:0]  m_we = 4'd0;
    logic [15:0] m_addr = 16'd0;
    logic [7:0]  m_data = 8'd0;
    logic        m_done = 1'b0;
    logic        m_oob = 1'b0;
    int          m_cnt = 0;
    logic [15:0] m_sum = 16'd0;

    task automatic start_load();
        m_phase = 1;
        m_cnt   = 0;
        m_oob   = 1'b0;
        m_done  = 1'b0;
        m_sum   = 16'd0;
    endtask

    task automatic model_step(input logic r, input logic dl, input logic w,
                              input logic [24:0] a, input logic [7:0] d);
        int hit;
        hit = -1;
        if (r) begin
            m_phase = 0; m_hold_left = 0; m_we = 4'd0; m_addr = 16'd0;
            m_data = 8'd0; m_done = 1'b0; m_oob = 1'b0; m_cnt = 0;
            m_sum = 16'd0;
        end else begin
            m_we = 4'd0;
            if (m_phase == 1 && w) begin
                for (int n = 0; n < 4; n++) begin
                    if (hit < 0 && int'(a) >= TB_BASE[n] &&
                        int'(a) < TB_BASE[n] + (1 << TB_AW[n])) begin
                        hit = n;
                    end
                end
                if (hit >= 0) begin
                    m_we   = 4'(1 << hit);
                    m_addr = 16'(int'(a) - TB_BASE[hit]);
                    m_data = d;
                    if (m_cnt < 'h1FFFF) m_cnt++;
                    m_sum  = 16'(int'(m_sum) + int'(d));
                end else begin
                    m_oob = 1'b1;
                end
            end
            if (m_phase == 1) begin
                if (!dl) begin
                    m_phase     = 2;
                    m_hold_left = HOLD;
                end
            end else if (m_phase == 2 && !dl) begin
                m_hold_left--;
                if (m_hold_left == 0) begin
                    m_phase = 3;
                    m_done  = 1'b1;
                end
            end else if (dl) begin
                start_load();
            end
        end
    endtask

    // Per-cycle comparison against the model, #1 after the active edge.
    initial begin
        forever begin
            logic ok;
            @(posedge clk_sys);
            model_step(reset, ioctl_download, ioctl_wr, ioctl_addr, ioctl_data);
            #1;
            ok = (rom_we === m_we) && (rom_addr === m_addr) &&
                 (rom_data === m_data) && (game_reset === (m_phase != 3)) &&
                 (load_done === m_done) && (oob_err === m_oob) &&
                 (byte_count === 17'(m_cnt));
`ifdef ROM_CHECKSUM_EN
            if (m_done && checksum !== m_sum) ok = 1'b0;
`endif
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL cycle_model t=%0t got we=%h addr=%h data=%h grst=%b done=%b oob=%b cnt=%h want we=%h addr=%h data=%h grst=%b done=%b oob=%b cnt=%h",
                         $time, rom_we, rom_addr, rom_data, game_reset, load_done,
                         oob_err, byte_count, m_we, m_addr, m_data, m_phase != 3,
                         m_done, m_oob, 17'(m_cnt));
            end
            for (int n = 0; n < 4; n++) if (rom_we[n]) region_hits[n]++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic put(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_data = d;
        tick();
        ioctl_wr = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int hi;
        reset = 1'b1;
        repeat (3) tick();
        chk("reset_we", 32'(rom_we), 0);
        chk("reset_grst", 32'(game_reset), 1);
        chk("reset_done", 32'(load_done), 0);
        chk("reset_cnt", 32'(byte_count), 0);
        chk("reset_oob", 32'(oob_err), 0);
        chk("reset_addr", 32'(rom_addr), 0);
        reset = 1'b0;
        tick();

        // Full sweep over the four default regions.
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) region_hits[i] = 0;
        for (int a = 0; a < 'h10000; a++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_data = 8'(a);
            tick();
        end
        ioctl_wr = 1'b0;
        tick();
        chk("sweep_cnt", 32'(byte_count), 'h10000);
        chk("sweep_oob", 32'(oob_err), 0);
        for (int n = 0; n < 4; n++) chk("sweep_region", 32'(region_hits[n]), 'h4000);

        // Hold stretch after download falls.
        ioctl_download = 1'b0;
        hi = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (game_reset) hi++;
            else break;
        end
        chk("hold_len", 32'(hi), 4);
        chk("hold_done", 32'(load_done), 1);

        // New load from RUN, out-of-range byte, write on the falling cycle.
        ioctl_download = 1'b1;
        tick();
        chk("reload_cnt", 32'(byte_count), 0);
        chk("reload_done", 32'(load_done), 0);
        put(25'h00010, 8'hAA);
        put(25'h10000, 8'h33);
        chk("oob_we", 32'(rom_we), 0);
        chk("oob_flag", 32'(oob_err), 1);
        chk("oob_cnt", 32'(byte_count), 1);
        ioctl_download = 1'b0;
        put(25'h0C005, 8'h5A);
        chk("fall_we", 32'(rom_we), 'b1000);
        chk("fall_addr", 32'(rom_addr), 5);
        chk("fall_data", 32'(rom_data), 'h5A);
        chk("fall_cnt", 32'(byte_count), 2);

        // Download returns two cycles into HOLD.
        tick();
        ioctl_download = 1'b1;
        tick();
        chk("rehold_grst", 32'(game_reset), 1);
        chk("rehold_done", 32'(load_done), 0);
        tick();
        chk("rehold_grst2", 32'(game_reset), 1);

        // Reset pulse coinciding with a write.
        ioctl_wr = 1'b1; ioctl_addr = 25'h04000; ioctl_data = 8'h11; reset = 1'b1;
        tick();
        ioctl_wr = 1'b0; reset = 1'b0;
        chk("rst_we", 32'(rom_we), 0);
        chk("rst_cnt", 32'(byte_count), 0);
        chk("rst_grst", 32'(game_reset), 1);
        tick();
        put(25'h04007, 8'h77);
        chk("rst_reload_we", 32'(rom_we), 'b0010);
        chk("rst_reload_addr", 32'(rom_addr), 7);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) ioctl_download = ~ioctl_download;
            ioctl_wr   = 1'($urandom_range(0, 1));
            ioctl_addr = ($urandom_range(0, 3) != 0) ? 25'($urandom_range(0, 'h10FFF))
                                                     : 25'($urandom);
            ioctl_data = 8'($urandom);
            reset      = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0; ioctl_wr = 1'b0; ioctl_download = 1'b0;
        repeat (2) tick();

        // 257 bytes of 'hFF: sum is 257*255 = 'hFFFF modulo 2^16.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 257; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_data = 8'hFF;
            tick();
        end
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        hi = 0;
        while (!load_done && hi < 50) begin
            tick();
            hi++;
        end
        chk("sum_done", 32'(load_done), 1);
        chk("sum_cnt", 32'(byte_count), 257);
`ifdef ROM_CHECKSUM_EN
        chk("sum_value", 32'(checksum), 'hFFFF);
`endif
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
